player_move: RTL and testbench
==============================

# player_move

Game-logic block that owns the player position shown by the maze renderer. It accepts the start/goal setup and debounced direction buttons, checks each requested step against the grid bounds and the shared 40-column wall map, and commits accepted moves only at frame boundaries signalled by the renderer. It drives the renderer's player-position inputs and the goal-reached flag.

## Interface
- No parameters. Map row pitch is fixed at 40 cells.
- i_Clk  in  1  system clock
- i_Rst  in  1  reset, asynchronous, active-low
- i_Level  in  2  grid size: 01 = 16x12, 10 = 32x24, 11 = 40x30, 00 = invalid
- i_Map  in  1200  wall map; cell (X,Y) is a wall when bit 1199-(Y*40+X) is 1
- i_Start  in  1  one-cycle pulse: load start position, clear game state
- i_StartPos_X / i_StartPos_Y  in  6 / 5  start cell
- i_GoalPos_X / i_GoalPos_Y  in  6 / 5  goal cell
- i_Btn  in  4  debounced buttons, active-high: [3] up, [2] down, [1] left, [0] right
- i_fDrawDone  in  1  one-cycle frame-complete pulse from the renderer
- o_PlayerPos_X / o_PlayerPos_Y  out  6 / 5  committed player cell
- o_fGoal  out  1  high while the player is on the goal
- o_Bump  out  1  one-cycle pulse on a rejected move
- o_MoveCnt  out  10  accepted moves since start, saturates at 1023
- o_Busy  out  1  high in CHECK or WAIT_FRAME

## Operation
- States: IDLE, READY, CHECK, WAIT_FRAME, GOAL. Reset enters IDLE.
- Edge detect: i_Btn is registered every cycle in every state. A rise is the registered sample = 1 while the previous sample = 0.
  - Priority when several bits rise in the same cycle: up > down > left > right.
  - A rise is acted on only in READY. Rises in any other state are dropped, not queued.
  - A held button never retriggers.
- i_Start has the highest priority in every state. On the next edge: position <= start cell, goal cell latched internally, o_MoveCnt <= 0, o_fGoal <= 0, state <= READY. Start and goal are loaded as given; no range check.
- IDLE: ignores buttons and i_fDrawDone; waits for i_Start.
- READY: on a rise, latch the direction and go to CHECK.
- CHECK:
  - Target = position ±1 in X or Y.
  - Bound limits: Xmax/Ymax = 15/11, 31/23, 39/29 for levels 01, 10, 11. Bounds are sampled from i_Level in this cycle.
  - Reject the move when any of these hold: the step would go below 0 or above Xmax/Ymax; the target wall bit is 1; i_Level = 00.
  - On reject: o_Bump pulses, position unchanged, state <= READY.
  - On accept: latch target as pending, state <= WAIT_FRAME.
- WAIT_FRAME: on the first cycle with i_fDrawDone = 1:
  - position <= pending; o_MoveCnt increments, saturating at 1023.
  - If pending equals the goal: o_fGoal <= 1, state <= GOAL. Otherwise state <= READY.
  - The pending position is held indefinitely until i_fDrawDone arrives.
- GOAL: buttons ignored, outputs frozen; only i_Start or reset leaves.
- Map or goal input changes mid-game: the wall check always uses the current i_Map, and the goal compare uses the latched goal.

## Timing
- All outputs are registered. Reset values: o_PlayerPos_X = 0, o_PlayerPos_Y = 0, o_fGoal = 0, o_Bump = 0, o_MoveCnt = 0, o_Busy = 0. Reset mid-operation discards the pending move.
- Clock numbering: rise seen in READY at edge N, CHECK at N+1. o_Bump or entry to WAIT_FRAME is visible after edge N+2.
- i_fDrawDone is sampled only in WAIT_FRAME. A pulse coinciding with the CHECK cycle is ignored, and the block waits for the next frame.
- The committed position and o_MoveCnt are visible the cycle after the edge that sampled i_fDrawDone. o_fGoal rises in that same cycle.
- i_Start coinciding with any button rise or i_fDrawDone: i_Start wins, and the pending move is discarded.
- o_Busy is combinational from the state register: high in CHECK or WAIT_FRAME.

## Test plan
- Basic move: empty map, level 01, start (1,1), goal (3,1). Rise i_Btn[0], then pulse i_fDrawDone -> position (2,1), o_MoveCnt = 1, o_Bump = 0.
- Wall: same setup with bit 1157 set (cell (2,1)). Press right -> o_Bump for exactly 1 cycle, position (1,1), o_MoveCnt = 0, i_fDrawDone has no effect.
- Bounds: level 01 at (15,5), press right -> bump. Level 11 at (15,5), press right + draw done -> (16,5). At (0,0), up and left each -> bump.
- Frame gating: accepted move, withhold i_fDrawDone for 1000 cycles while raising i_Btn[2] -> position unchanged, o_Busy = 1. Then draw done -> only the first move commits, o_MoveCnt = 1.
- Goal: step onto (3,1) -> o_fGoal = 1. Further presses and draw-done pulses change nothing. i_Start -> o_fGoal = 0, position = start, o_MoveCnt = 0.
- Reset mid-move: assert i_Rst low in WAIT_FRAME -> all outputs 0 immediately (asynchronous), state IDLE. Button presses after release do nothing until i_Start.

Source files
------------

// File: rtl/player_move.sv
// rtl/player_move.sv - player position owner: button edge detect, bounds/wall check, frame-gated commit
// Moves are validated against the live wall map and committed only on a renderer frame-done pulse.
module player_move (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [1:0]    i_Level,
  input  logic [1199:0] i_Map,
  input  logic          i_Start,
  input  logic [5:0]    i_StartPos_X,
  input  logic [4:0]    i_StartPos_Y,
  input  logic [5:0]    i_GoalPos_X,
  input  logic [4:0]    i_GoalPos_Y,
  input  logic [3:0]    i_Btn,
  input  logic          i_fDrawDone,
  output logic [5:0]    o_PlayerPos_X,
  output logic [4:0]    o_PlayerPos_Y,
  output logic          o_fGoal,
  output logic          o_Bump,
  output logic [9:0]    o_MoveCnt,
  output logic          o_Busy
);

  typedef enum logic [2:0] {IDLE, READY, CHECK, WAIT_FRAME, GOAL} state_t;

  state_t      r_State, w_State;
  logic [3:0]  r_BtnS, r_BtnP;
  logic [3:0]  w_Rise;
  logic [1:0]  r_Dir, w_Dir;
  logic [5:0]  r_PosX, w_PosX, r_PendX, w_PendX, r_GoalX, w_GoalX;
  logic [4:0]  r_PosY, w_PosY, r_PendY, w_PendY, r_GoalY, w_GoalY;
  logic        r_fGoal, w_fGoal, r_Bump, w_Bump;
  logic [9:0]  r_MoveCnt, w_MoveCnt;
  logic [5:0]  w_Xmax;
  logic [4:0]  w_Ymax;
  logic [6:0]  w_TgtX;
  logic [5:0]  w_TgtY;
  logic [11:0] w_Idx;
  logic [10:0] w_MapBit;
  logic        w_Wall, w_Reject;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_BtnS <= 4'd0;
      r_BtnP <= 4'd0;
    end else begin
      r_BtnS <= i_Btn;
      r_BtnP <= r_BtnS;
    end
  end

  assign w_Rise = r_BtnS & ~r_BtnP;

  always_comb begin
    w_Xmax = 6'd0;
    w_Ymax = 5'd0;
    case (i_Level)
      2'b01:   begin w_Xmax = 6'd15; w_Ymax = 5'd11; end
      2'b10:   begin w_Xmax = 6'd31; w_Ymax = 5'd23; end
      2'b11:   begin w_Xmax = 6'd39; w_Ymax = 5'd29; end
      default: ;
    endcase
  end

  // One extra bit on the target so a step below 0 wraps to all-ones and fails the upper bound test.
  always_comb begin
    w_TgtX = {1'b0, r_PosX};
    w_TgtY = {1'b0, r_PosY};
    case (r_Dir)
      2'd0:    w_TgtY = {1'b0, r_PosY} - 6'd1;
      2'd1:    w_TgtY = {1'b0, r_PosY} + 6'd1;
      2'd2:    w_TgtX = {1'b0, r_PosX} - 7'd1;
      default: w_TgtX = {1'b0, r_PosX} + 7'd1;
    endcase
  end

  assign w_Idx    = 12'(w_TgtY) * 12'd40 + 12'(w_TgtX);
  assign w_MapBit = 11'(12'd1199 - w_Idx);
  assign w_Wall   = (w_Idx <= 12'd1199) ? i_Map[w_MapBit] : 1'b1;
  assign w_Reject = w_Wall | (i_Level == 2'b00) |
                    (w_TgtX > {1'b0, w_Xmax}) | (w_TgtY > {1'b0, w_Ymax});

  always_comb begin
    w_State   = r_State;
    w_Dir     = r_Dir;
    w_PosX    = r_PosX;
    w_PosY    = r_PosY;
    w_PendX   = r_PendX;
    w_PendY   = r_PendY;
    w_GoalX   = r_GoalX;
    w_GoalY   = r_GoalY;
    w_fGoal   = r_fGoal;
    w_Bump    = 1'b0;
    w_MoveCnt = r_MoveCnt;
    if (i_Start) begin
      w_State   = READY;
      w_PosX    = i_StartPos_X;
      w_PosY    = i_StartPos_Y;
      w_GoalX   = i_GoalPos_X;
      w_GoalY   = i_GoalPos_Y;
      w_fGoal   = 1'b0;
      w_MoveCnt = 10'd0;
    end else begin
      case (r_State)
        READY: begin
          if (|w_Rise) begin
            w_State = CHECK;
            if (w_Rise[3])      w_Dir = 2'd0;
            else if (w_Rise[2]) w_Dir = 2'd1;
            else if (w_Rise[1]) w_Dir = 2'd2;
            else                w_Dir = 2'd3;
          end
        end
        CHECK: begin
          if (w_Reject) begin
            w_Bump  = 1'b1;
            w_State = READY;
          end else begin
            w_PendX = w_TgtX[5:0];
            w_PendY = w_TgtY[4:0];
            w_State = WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (i_fDrawDone) begin
            w_PosX = r_PendX;
            w_PosY = r_PendY;
            if (r_MoveCnt != 10'h3FF) w_MoveCnt = r_MoveCnt + 10'd1;
            if (r_PendX == r_GoalX && r_PendY == r_GoalY) begin
              w_fGoal = 1'b1;
              w_State = GOAL;
            end else begin
              w_State = READY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State   <= IDLE;
      r_Dir     <= 2'd0;
      r_PosX    <= 6'd0;
      r_PosY    <= 5'd0;
      r_PendX   <= 6'd0;
      r_PendY   <= 5'd0;
      r_GoalX   <= 6'd0;
      r_GoalY   <= 5'd0;
      r_fGoal   <= 1'b0;
      r_Bump    <= 1'b0;
      r_MoveCnt <= 10'd0;
    end else begin
      r_State   <= w_State;
      r_Dir     <= w_Dir;
      r_PosX    <= w_PosX;
      r_PosY    <= w_PosY;
      r_PendX   <= w_PendX;
      r_PendY   <= w_PendY;
      r_GoalX   <= w_GoalX;
      r_GoalY   <= w_GoalY;
      r_fGoal   <= w_fGoal;
      r_Bump    <= w_Bump;
      r_MoveCnt <= w_MoveCnt;
    end
  end

  assign o_PlayerPos_X = r_PosX;
  assign o_PlayerPos_Y = r_PosY;
  assign o_fGoal       = r_fGoal;
  assign o_Bump        = r_Bump;
  assign o_MoveCnt     = r_MoveCnt;
  assign o_Busy        = (r_State == CHECK) || (r_State == WAIT_FRAME);

endmodule

// File: tb/tb_player_move.sv
// tb/tb_player_move.sv - randomized self-checking bench for player_move against a grid-level game model
module tb_player_move;

  logic          i_Clk = 1'b0;
  logic          i_Rst = 1'b0;
  logic [1:0]    i_Level = 2'b01;
  logic [1199:0] i_Map = '0;
  logic          i_Start = 1'b0;
  logic [5:0]    i_StartPos_X = 6'd0;
  logic [4:0]    i_StartPos_Y = 5'd0;
  logic [5:0]    i_GoalPos_X = 6'd0;
  logic [4:0]    i_GoalPos_Y = 5'd0;
  logic [3:0]    i_Btn = 4'd0;
  logic          i_fDrawDone = 1'b0;
  logic [5:0]    o_PlayerPos_X;
  logic [4:0]    o_PlayerPos_Y;
  logic          o_fGoal, o_Bump, o_Busy;
  logic [9:0]    o_MoveCnt;

  player_move dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Level(i_Level), .i_Map(i_Map), .i_Start(i_Start),
    .i_StartPos_X(i_StartPos_X), .i_StartPos_Y(i_StartPos_Y),
    .i_GoalPos_X(i_GoalPos_X), .i_GoalPos_Y(i_GoalPos_Y),
    .i_Btn(i_Btn), .i_fDrawDone(i_fDrawDone),
    .o_PlayerPos_X(o_PlayerPos_X), .o_PlayerPos_Y(o_PlayerPos_Y),
    .o_fGoal(o_fGoal), .o_Bump(o_Bump), .o_MoveCnt(o_MoveCnt), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Game model: 0 idle, 1 ready, 2 move pending, 3 on goal
  int m_st = 0;
  int m_x = 0, m_y = 0, m_px = 0, m_py = 0, m_gx = 0, m_gy = 0, m_cnt = 0, m_goal = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit model_reject(input int nx, input int ny);
    int xm, ym;
    case (i_Level)
      2'b01:   begin xm = 15; ym = 11; end
      2'b10:   begin xm = 31; ym = 23; end
      2'b11:   begin xm = 39; ym = 29; end
      default: return 1'b1;
    endcase
    if (nx < 0 || ny < 0 || nx > xm || ny > ym) return 1'b1;
    return i_Map[1199 - (ny * 40 + nx)];
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_x"}, 32'(o_PlayerPos_X), m_x);
    check({tag, "_y"}, 32'(o_PlayerPos_Y), m_y);
    check({tag, "_cnt"}, 32'(o_MoveCnt), m_cnt);
    check({tag, "_goal"}, 32'(o_fGoal), m_goal);
  endtask

  task automatic start(input int sx, input int sy, input int gx, input int gy);
    @(negedge i_Clk);
    i_StartPos_X = 6'(sx); i_StartPos_Y = 5'(sy);
    i_GoalPos_X = 6'(gx);  i_GoalPos_Y = 5'(gy);
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    m_st = 1; m_x = sx; m_y = sy; m_gx = gx; m_gy = gy; m_cnt = 0; m_goal = 0;
    check_outputs("start");
    check("start_busy", 32'(o_Busy), 0);
  endtask

  task automatic press(input logic [3:0] btn);
    int bumps = 0, busy_seen = 0, nx, ny;
    nx = m_x; ny = m_y;
    if (btn[3])      ny = m_y - 1;
    else if (btn[2]) ny = m_y + 1;
    else if (btn[1]) nx = m_x - 1;
    else             nx = m_x + 1;
    @(negedge i_Clk);
    i_Btn = btn;
    repeat (8) begin
      @(negedge i_Clk);
      bumps += int'(o_Bump);
      if (o_Busy) busy_seen = 1;
    end
    i_Btn = 4'd0;
    repeat (2) begin
      @(negedge i_Clk);
      bumps += int'(o_Bump);
    end
    if (m_st == 1) begin
      if (model_reject(nx, ny)) begin
        check("bump_once", bumps, 1);
        check("busy_after_bump", 32'(o_Busy), 0);
      end else begin
        check("accept_no_bump", bumps, 0);
        check("accept_busy", 32'(o_Busy), 1);
        m_st = 2; m_px = nx; m_py = ny;
      end
    end else begin
      check("ignored_bump", bumps, 0);
      check("ignored_busy", busy_seen, (m_st == 2) ? 1 : 0);
    end
    check_outputs("press");
  endtask

  task automatic draw_done();
    @(negedge i_Clk);
    i_fDrawDone = 1'b1;
    @(negedge i_Clk);
    i_fDrawDone = 1'b0;
    if (m_st == 2) begin
      m_x = m_px; m_y = m_py;
      if (m_cnt < 1023) m_cnt++;
      if (m_x == m_gx && m_y == m_gy) begin m_goal = 1; m_st = 3; end
      else m_st = 1;
    end
    check_outputs("draw");
    check("draw_busy", 32'(o_Busy), (m_st == 2) ? 1 : 0);
  endtask

  initial begin
    int sx, sy, gx, gy, xm, ym;
    bit seen;

    repeat (3) @(negedge i_Clk);
    check_outputs("reset");
    check("reset_bump", 32'(o_Bump), 0);
    check("reset_busy", 32'(o_Busy), 0);
    i_Rst = 1'b1;
    press(4'b0001);
    draw_done();

    // basic move then wall to the right
    i_Level = 2'b01; i_Map = '0;
    start(1, 1, 3, 1);
    press(4'b0001);
    draw_done();
    start(1, 1, 3, 1);
    i_Map[1157] = 1'b1;
    press(4'b0001);
    draw_done();
    i_Map = '0;

    // grid bounds
    start(15, 5, 0, 0);
    press(4'b0001);
    i_Level = 2'b11;
    start(15, 5, 0, 0);
    press(4'b0001);
    draw_done();
    start(0, 0, 39, 29);
    press(4'b1000);
    press(4'b0010);
    i_Level = 2'b00;
    press(4'b0001);
    i_Level = 2'b01;
    press(4'b0101);
    draw_done();

    // frame gating: a held second button and 1000 idle cycles must not commit anything
    start(4, 4, 9, 9);
    press(4'b0001);
    i_Btn = 4'b0100;
    repeat (1000) @(negedge i_Clk);
    check("gate_busy", 32'(o_Busy), 1);
    check_outputs("gate");
    i_Btn = 4'd0;
    repeat (2) @(negedge i_Clk);
    draw_done();

    // a frame pulse during the check cycle is ignored
    @(negedge i_Clk);
    i_Btn = 4'b0001;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge i_Clk);
      if (o_Busy) seen = 1'b1;
    end
    check("early_busy_seen", 32'(seen), 1);
    i_fDrawDone = 1'b1;
    @(negedge i_Clk);
    i_fDrawDone = 1'b0;
    i_Btn = 4'd0;
    repeat (3) @(negedge i_Clk);
    m_st = 2; m_px = m_x + 1; m_py = m_y;
    check("early_draw_busy", 32'(o_Busy), 1);
    check_outputs("early_draw");
    draw_done();

    // goal reached freezes everything until restart
    start(1, 1, 3, 1);
    press(4'b0001); draw_done();
    press(4'b0001); draw_done();
    press(4'b0100); draw_done();
    press(4'b0010); draw_done();
    start(1, 1, 3, 1);

    // start wins over a coincident frame pulse
    press(4'b0001);
    @(negedge i_Clk);
    i_StartPos_X = 6'd4; i_StartPos_Y = 5'd4; i_GoalPos_X = 6'd9; i_GoalPos_Y = 5'd9;
    i_Start = 1'b1; i_fDrawDone = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0; i_fDrawDone = 1'b0;
    m_st = 1; m_x = 4; m_y = 4; m_gx = 9; m_gy = 9; m_cnt = 0; m_goal = 0;
    check_outputs("start_wins");
    check("start_wins_busy", 32'(o_Busy), 0);

    // asynchronous reset in the middle of a pending move
    press(4'b0100);
    @(negedge i_Clk);
    #2 i_Rst = 1'b0;
    #1;
    m_st = 0; m_x = 0; m_y = 0; m_cnt = 0; m_goal = 0;
    check_outputs("async_rst");
    check("async_rst_busy", 32'(o_Busy), 0);
    check("async_rst_bump", 32'(o_Bump), 0);
    @(negedge i_Clk);
    i_Rst = 1'b1;
    press(4'b0001);
    draw_done();

    // move counter saturation
    i_Level = 2'b11; i_Map = '0;
    start(0, 0, 39, 29);
    for (int k = 0; k < 1030; k++) begin
      press((k % 2 == 0) ? 4'b0001 : 4'b0010);
      draw_done();
    end

    // randomized games on random maps
    for (int it = 0; it < 250; it++) begin
      if (it % 50 == 0 || m_st == 3 || m_st == 0) begin
        i_Level = 2'($urandom_range(1, 3));
        for (int b = 0; b < 1200; b++) i_Map[b] = ($urandom_range(0, 5) == 0);
        xm = (i_Level == 2'b01) ? 15 : (i_Level == 2'b10) ? 31 : 39;
        ym = (i_Level == 2'b01) ? 11 : (i_Level == 2'b10) ? 23 : 29;
        sx = int'($urandom_range(0, xm)); sy = int'($urandom_range(0, ym));
        gx = sx + int'($urandom_range(0, 2)); gy = sy + int'($urandom_range(0, 2));
        if (gx > xm) gx = xm;
        if (gy > ym) gy = ym;
        i_Map[1199 - (sy * 40 + sx)] = 1'b0;
        i_Map[1199 - (gy * 40 + gx)] = 1'b0;
        start(sx, sy, gx, gy);
      end
      if ($urandom_range(0, 15) == 0) i_Level = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) i_Map[$urandom_range(0, 1199)] = 1'($urandom_range(0, 1));
      press(4'($urandom_range(1, 15)));
      if ($urandom_range(0, 4) != 0) draw_done();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
